// File: rtl/parking_entry_keypad.sv
// Entry-side credential front end: sensor synchronization and debouncing,
// two-digit keypad code collection, and a timed code hand-off to the
// gate controller (entry_detect pulse plus held pass_1/pass_2).

// Two-flop synchronizer followed by a stability debouncer with edge flags.
module parking_entry_keypad_deb #(
   parameter int DEBOUNCE = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);
   localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          level_q;

   // Synchronize, then accept a new level only after DEBOUNCE differing cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync    <= 2'b00;
         cnt     <= '0;
         level   <= 1'b0;
         level_q <= 1'b0;
      end else begin
         sync    <= {sync[0], raw};
         level_q <= level;
         if (sync[1] != level) begin
            if (cnt == CMAX) begin
               level <= sync[1];
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign rise = level & ~level_q;
   assign fall = ~level & level_q;
endmodule

module parking_entry_keypad #(
   parameter int HOLD_CYCLES = 8,
   parameter int TIMEOUT     = 1000,
   parameter int DEBOUNCE    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       car_present,
   input  logic       car_leaving,
   output logic       entry_detect,
   output logic       exit_detect,
   output logic [1:0] pass_1,
   output logic [1:0] pass_2,
   output logic       busy,
   output logic       key_err
);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [TW-1:0] TMR_MAX  = TW'(TIMEOUT - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
   localparam logic [3:0] K_CLEAR = 4'hA;
   localparam logic [3:0] K_ENTER = 4'hE;

   typedef enum logic [2:0] {IDLE, DIGIT1, DIGIT2, CONFIRM, SEND} state_t;

   state_t        state, state_nxt;
   logic [1:0]    d1, d2, d1_nxt, d2_nxt;
   logic [TW-1:0] tmr, tmr_nxt;
   logic [HW-1:0] hold, hold_nxt;
   logic          err_nxt;
   logic          pres_lvl, pres_rise, pres_fall;
   logic          leave_lvl, leave_rise, leave_fall;
   logic          is_digit, is_clear, is_enter;

   parking_entry_keypad_deb #(.DEBOUNCE(DEBOUNCE)) u_pres_deb (
      .clk(clk), .rst_n(rst_n), .raw(car_present),
      .level(pres_lvl), .rise(pres_rise), .fall(pres_fall)
   );

   parking_entry_keypad_deb #(.DEBOUNCE(DEBOUNCE)) u_leave_deb (
      .clk(clk), .rst_n(rst_n), .raw(car_leaving),
      .level(leave_lvl), .rise(leave_rise), .fall(leave_fall)
   );

   assign is_digit = (key_code[3:2] == 2'b00);
   assign is_clear = (key_code == K_CLEAR);
   assign is_enter = (key_code == K_ENTER);

   // Next state, digit capture, inter-key timer and SEND hold counter.
   // Priority while collecting: car departure, then key, then timeout.
   always_comb begin
      state_nxt = state;
      d1_nxt    = d1;
      d2_nxt    = d2;
      tmr_nxt   = tmr;
      hold_nxt  = hold;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            d1_nxt  = 2'b00;
            d2_nxt  = 2'b00;
            tmr_nxt = '0;
            if (pres_rise) state_nxt = DIGIT1;
         end
         DIGIT1, DIGIT2, CONFIRM: begin
            if (pres_fall) begin
               state_nxt = IDLE;
               d1_nxt    = 2'b00;
               d2_nxt    = 2'b00;
               tmr_nxt   = '0;
            end else if (key_valid) begin
               tmr_nxt = '0;
               if (state == DIGIT1) begin
                  if (is_digit) begin
                     d1_nxt    = key_code[1:0];
                     state_nxt = DIGIT2;
                  end else if (!is_clear) begin
                     err_nxt = 1'b1;
                  end
               end else if (state == DIGIT2) begin
                  if (is_digit) begin
                     d2_nxt    = key_code[1:0];
                     state_nxt = CONFIRM;
                  end else if (is_clear) begin
                     d1_nxt    = 2'b00;
                     state_nxt = DIGIT1;
                  end else begin
                     err_nxt = 1'b1;
                  end
               end else begin
                  if (is_enter) begin
                     hold_nxt  = '0;
                     state_nxt = SEND;
                  end else if (is_clear) begin
                     d1_nxt    = 2'b00;
                     d2_nxt    = 2'b00;
                     state_nxt = DIGIT1;
                  end else begin
                     err_nxt = 1'b1;
                  end
               end
            end else if (tmr == TMR_MAX) begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
               d1_nxt    = 2'b00;
               d2_nxt    = 2'b00;
               tmr_nxt   = '0;
            end else begin
               tmr_nxt = tmr + TW'(1);
            end
         end
         SEND: begin
            if (hold == HOLD_MAX) begin
               hold_nxt  = '0;
               state_nxt = IDLE;
            end else begin
               hold_nxt = hold + HW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, working registers and registered outputs derived from next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         d1           <= 2'b00;
         d2           <= 2'b00;
         tmr          <= '0;
         hold         <= '0;
         entry_detect <= 1'b0;
         exit_detect  <= 1'b0;
         pass_1       <= 2'b00;
         pass_2       <= 2'b00;
         busy         <= 1'b0;
         key_err      <= 1'b0;
      end else begin
         state        <= state_nxt;
         d1           <= d1_nxt;
         d2           <= d2_nxt;
         tmr          <= tmr_nxt;
         hold         <= hold_nxt;
         entry_detect <= (state == CONFIRM) && (state_nxt == SEND);
         exit_detect  <= leave_rise;
         pass_1       <= (state_nxt == SEND) ? d1_nxt : 2'b00;
         pass_2       <= (state_nxt == SEND) ? d2_nxt : 2'b00;
         busy         <= (state_nxt != IDLE);
         key_err      <= err_nxt;
      end
   end
endmodule

// File: tb/tb_parking_entry_keypad.sv
// Directed bench for parking_entry_keypad (DEBOUNCE=4, HOLD_CYCLES=8,
// TIMEOUT=1000).
module tb_parking_entry_keypad;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'h0;
   logic       car_present = 1'b0;
   logic       car_leaving = 1'b0;
   logic       entry_detect, exit_detect, busy, key_err;
   logic [1:0] pass_1, pass_2;

   int checks = 0;
   int errors = 0;
   int pulses;

   parking_entry_keypad #(.HOLD_CYCLES(8), .TIMEOUT(1000), .DEBOUNCE(4)) dut (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
      .car_present(car_present), .car_leaving(car_leaving),
      .entry_detect(entry_detect), .exit_detect(exit_detect),
      .pass_1(pass_1), .pass_2(pass_2), .busy(busy), .key_err(key_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n clock edges, landing 1ns after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-cycle key strobe; returns 1ns after the sampling edge.
   task automatic key(input logic [3:0] code);
      key_valid = 1'b1;
      key_code  = code;
      tick(1);
      key_valid = 1'b0;
      key_code  = 4'h0;
   endtask

   // Fresh car arrival: lower, settle, raise, wait the 7-cycle sensor latency.
   task automatic car_arrive();
      car_present = 1'b0;
      tick(10);
      car_present = 1'b1;
      tick(7);
   endtask

   initial begin
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_entry", entry_detect, 0);
      chk("rst_pass", {pass_1, pass_2}, 0);
      chk("rst_err", key_err, 0);
      chk("rst_exit", exit_detect, 0);
      rst_n = 1'b1;
      tick(2);

      // Normal entry: 1, 2, E
      car_present = 1'b1;
      tick(6);
      chk("lat_busy_early", busy, 0);
      tick(1);
      chk("lat_busy", busy, 1);
      key(4'h1);
      key(4'h2);
      key(4'hE);
      chk("n_entry", entry_detect, 1);
      chk("n_pass1", pass_1, 2'b01);
      chk("n_pass2", pass_2, 2'b10);
      for (int i = 0; i < 7; i++) begin
         tick(1);
         chk("n_entry_low", entry_detect, 0);
         chk("n_hold", {pass_1, pass_2}, 4'b0110);
         chk("n_hold_busy", busy, 1);
      end
      tick(1);
      chk("n_pass_end", {pass_1, pass_2}, 0);
      chk("n_busy_end", busy, 0);

      // Key errors: E, 7, 1, 3, 2, E
      car_arrive();
      key(4'hE); chk("e_err_enter", key_err, 1);
      key(4'h7); chk("e_err_inv", key_err, 1);
      key(4'h1); chk("e_ok1", key_err, 0);
      key(4'h3); chk("e_ok3", key_err, 0);
      key(4'h2); chk("e_err_conf", key_err, 1);
      key(4'hE);
      chk("e_entry", entry_detect, 1);
      chk("e_pass", {pass_1, pass_2}, 4'b0111);
      chk("e_err_clr", key_err, 0);
      tick(8);
      chk("e_busy_end", busy, 0);

      // CLEAR: 1, A, 2, 0, E
      car_arrive();
      key(4'h1); key(4'hA); key(4'h2); key(4'h0); key(4'hE);
      chk("c_entry", entry_detect, 1);
      chk("c_pass", {pass_1, pass_2}, 4'b1000);
      tick(8);
      chk("c_busy_end", busy, 0);

      // Timeout in DIGIT2
      car_arrive();
      key(4'h1);
      tick(999);
      chk("t_no_err_yet", key_err, 0);
      chk("t_busy_yet", busy, 1);
      tick(1);
      chk("t_err", key_err, 1);
      chk("t_idle", busy, 0);
      chk("t_no_entry", entry_detect, 0);
      tick(1);
      chk("t_err_pulse", key_err, 0);

      // Exit glitch of 3 cycles: no pulse
      pulses = 0;
      car_leaving = 1'b1;
      for (int i = 0; i < 3; i++) begin tick(1); pulses += int'(exit_detect); end
      car_leaving = 1'b0;
      for (int i = 0; i < 12; i++) begin tick(1); pulses += int'(exit_detect); end
      chk("x_glitch", pulses, 0);

      // Exit 10 cycles high while in CONFIRM: exactly one pulse at +7
      car_arrive();
      key(4'h1); key(4'h2);
      car_leaving = 1'b1;
      pulses = 0;
      for (int i = 1; i <= 10; i++) begin
         tick(1);
         pulses += int'(exit_detect);
         if (i == 7) chk("x_pulse_at7", exit_detect, 1);
      end
      car_leaving = 1'b0;
      for (int i = 0; i < 12; i++) begin tick(1); pulses += int'(exit_detect); end
      chk("x_one_pulse", pulses, 1);
      chk("x_confirm_busy", busy, 1);
      key(4'hE);
      chk("x_entry", entry_detect, 1);
      tick(8);
      chk("x_busy_end", busy, 0);

      // Car departs in DIGIT2, with an invalid key on the fall cycle
      car_arrive();
      key(4'h1);
      car_present = 1'b0;
      tick(6);
      chk("d_busy_before", busy, 1);
      key(4'h7);
      chk("d_idle", busy, 0);
      chk("d_no_err", key_err, 0);
      tick(1);
      chk("d_no_err2", key_err, 0);

      // Reset in SEND cycle 3
      car_arrive();
      key(4'h3); key(4'h1); key(4'hE);
      tick(2);
      chk("r_pre_pass", {pass_1, pass_2}, 4'b1101);
      #2 rst_n = 1'b0;
      #1;
      chk("r_pass", {pass_1, pass_2}, 0);
      chk("r_busy", busy, 0);
      chk("r_entry", entry_detect, 0);
      #1 rst_n = 1'b1;
      tick(3);
      chk("r_stay_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
